// File: rtl/clk_div_tog_ctrl.sv
// Per-domain clock-divider control: emits a clock-enable pulse once per DIV+1 cycles and applies
// a new divisor only at a period boundary after a TOG level change, so no runt periods appear.
module clk_div_tog_ctrl #(
  parameter int unsigned     DIV_W    = 4,
  parameter logic [DIV_W-1:0] DIV_RST = '0,
  parameter logic            TOG_RST  = 1'b1,
  parameter logic            CKEN_RST = 1'b1,
  parameter logic            ICG_RST  = 1'b1
) (
  input  logic             p_clk,
  input  logic             p_rst,
  input  logic [DIV_W-1:0] reg_div_i,
  input  logic             reg_tog_i,
  input  logic             reg_cken_i,
  input  logic             reg_icg_on_i,
  output logic             clk_en_o,
  output logic [DIV_W-1:0] div_cur_o,
  output logic             busy_o,
  output logic             upd_done_o
);

  typedef enum logic [1:0] {StRun, StSwitch, StOff} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pend_q, pend_d;
  logic             clk_en_q, clk_en_d;
  logic             upd_done_q, upd_done_d;

  logic tog_s1_q, tog_s2_q, tog_prev_q;
  logic cken_s1_q, cken_s2_q;
  logic icg_s1_q, icg_s2_q;

  logic tog_edge;
  logic tick;

  assign tog_edge = tog_s2_q ^ tog_prev_q;
  // The counter is parked at zero while stopped, so OFF must never produce a tick.
  assign tick     = (state_q != StOff) && (cnt_q == div_q);

  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      tog_s1_q   <= TOG_RST;
      tog_s2_q   <= TOG_RST;
      tog_prev_q <= TOG_RST;
      cken_s1_q  <= CKEN_RST;
      cken_s2_q  <= CKEN_RST;
      icg_s1_q   <= ICG_RST;
      icg_s2_q   <= ICG_RST;
    end else begin
      tog_s1_q   <= reg_tog_i;
      tog_s2_q   <= tog_s1_q;
      tog_prev_q <= tog_s2_q;
      cken_s1_q  <= reg_cken_i;
      cken_s2_q  <= cken_s1_q;
      icg_s1_q   <= reg_icg_on_i;
      icg_s2_q   <= icg_s1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    upd_done_d = 1'b0;
    clk_en_d   = tick & icg_s2_q;

    unique case (state_q)
      StRun: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick && !cken_s2_q) begin
          // Stop wins over a same-cycle toggle; the toggle is remembered as pending.
          state_d = StOff;
          pend_d  = pend_q | tog_edge;
        end else if (tog_edge) begin
          state_d = StSwitch;
          pend_d  = 1'b1;
        end
      end
      StSwitch: begin
        if (tick) begin
          cnt_d = '0;
          if (!cken_s2_q) begin
            state_d = StOff;
          end else begin
            state_d    = StRun;
            div_d      = reg_div_i;
            pend_d     = 1'b0;
            upd_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOff: begin
        cnt_d = '0;
        if (tog_edge) begin
          pend_d = 1'b1;
        end
        if (cken_s2_q) begin
          state_d    = StRun;
          div_d      = reg_div_i;
          upd_done_d = pend_q;
          pend_d     = 1'b0;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      div_q      <= DIV_RST;
      pend_q     <= 1'b0;
      clk_en_q   <= 1'b0;
      upd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      clk_en_q   <= clk_en_d;
      upd_done_q <= upd_done_d;
    end
  end

  assign clk_en_o   = clk_en_q;
  assign div_cur_o  = div_q;
  assign busy_o     = pend_q;
  assign upd_done_o = upd_done_q;

endmodule

// File: tb/tb_clk_div_tog_ctrl.sv
// Directed plus randomized bench for clk_div_tog_ctrl against a cycle-level behavioural model.
module tb_clk_div_tog_ctrl;

  logic       p_clk;
  logic       p_rst;
  logic [3:0] reg_div_i;
  logic       reg_tog_i;
  logic       reg_cken_i;
  logic       reg_icg_on_i;
  logic       clk_en_o;
  logic [3:0] div_cur_o;
  logic       busy_o;
  logic       upd_done_o;

  int vectors;
  int miscompares;

  clk_div_tog_ctrl #(
    .DIV_W   (4),
    .DIV_RST (4'h0),
    .TOG_RST (1'b1),
    .CKEN_RST(1'b1),
    .ICG_RST (1'b1)
  ) dut (
    .p_clk       (p_clk),
    .p_rst       (p_rst),
    .reg_div_i   (reg_div_i),
    .reg_tog_i   (reg_tog_i),
    .reg_cken_i  (reg_cken_i),
    .reg_icg_on_i(reg_icg_on_i),
    .clk_en_o    (clk_en_o),
    .div_cur_o   (div_cur_o),
    .busy_o      (busy_o),
    .upd_done_o  (upd_done_o)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  // Reference model: inputs seen through a two-stage delay line, period position in the
  // current divided period, and whether the divider is running, waiting to switch, or stopped.
  bit tog_dl[2], cken_dl[2], icg_dl[2];
  bit tog_seen;
  int phase;
  int ratio_m1;
  bit stopped, switching, pending;
  bit m_en, m_upd;

  function automatic void model_reset();
    tog_dl = '{1'b1, 1'b1};
    cken_dl = '{1'b1, 1'b1};
    icg_dl = '{1'b1, 1'b1};
    tog_seen = 1'b1;
    phase = 0;
    ratio_m1 = 0;
    stopped = 0;
    switching = 0;
    pending = 0;
    m_en = 0;
    m_upd = 0;
  endfunction

  function automatic void model_step(bit rst, int div_in, bit tog_in, bit cken_in, bit icg_in);
    bit toggled, boundary, running;
    if (rst) begin
      model_reset();
      return;
    end
    toggled  = (tog_dl[1] != tog_seen);
    running  = cken_dl[1];
    boundary = !stopped && (phase == ratio_m1);
    m_en  = boundary && icg_dl[1];
    m_upd = 0;
    if (stopped) begin
      if (toggled) pending = 1;
      if (running) begin
        stopped  = 0;
        ratio_m1 = div_in;
        m_upd    = pending;
        pending  = 0;
      end
      phase = 0;
    end else if (boundary) begin
      phase = 0;
      if (!running) begin
        stopped = 1;
        if (toggled) pending = 1;
        switching = 0;
      end else if (switching) begin
        ratio_m1  = div_in;
        pending   = 0;
        switching = 0;
        m_upd     = 1;
      end else if (toggled) begin
        switching = 1;
        pending   = 1;
      end
    end else begin
      phase = phase + 1;
      if (toggled && !switching) begin
        switching = 1;
        pending   = 1;
      end
    end
    tog_seen = tog_dl[1];
    tog_dl[1] = tog_dl[0];   tog_dl[0] = tog_in;
    cken_dl[1] = cken_dl[0]; cken_dl[0] = cken_in;
    icg_dl[1] = icg_dl[0];   icg_dl[0] = icg_in;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("clk_en", {31'd0, clk_en_o}, {31'd0, m_en});
    check("div_cur", {28'd0, div_cur_o}, ratio_m1);
    check("busy", {31'd0, busy_o}, {31'd0, pending});
    check("upd_done", {31'd0, upd_done_o}, {31'd0, m_upd});
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step(p_rst, reg_div_i, reg_tog_i, reg_cken_i, reg_icg_on_i);
      @(posedge p_clk);
      #1;
      check_all();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    p_rst = 1'b1;
    reg_div_i = 4'd0;
    reg_tog_i = 1'b1;
    reg_cken_i = 1'b1;
    reg_icg_on_i = 1'b1;
    model_reset();
    #1;
    check_all();
    cyc(2);
    p_rst = 1'b0;

    // Bypass: enable every cycle.
    cyc(6);
    check("bypass_en", {31'd0, clk_en_o}, 32'd1);

    // Divide by 4.
    reg_div_i = 4'd3;
    reg_tog_i = ~reg_tog_i;
    cyc(20);
    check("div3_cur", {28'd0, div_cur_o}, 32'd3);

    // Double toggle and late divisor change: single apply, latest value wins.
    reg_div_i = 4'd7;
    reg_tog_i = ~reg_tog_i;
    cyc(1);
    reg_tog_i = ~reg_tog_i;
    reg_div_i = 4'd5;
    cyc(24);
    check("div5_cur", {28'd0, div_cur_o}, 32'd5);

    // Stop mid-period, then restart with a new divisor.
    reg_div_i = 4'd3;
    reg_tog_i = ~reg_tog_i;
    cyc(14);
    reg_cken_i = 1'b0;
    cyc(15);
    reg_div_i = 4'd1;
    reg_tog_i = ~reg_tog_i;
    cyc(3);
    reg_cken_i = 1'b1;
    cyc(12);
    check("restart_cur", {28'd0, div_cur_o}, 32'd1);

    // Gating only masks the enable; phase grid is kept.
    reg_div_i = 4'd2;
    reg_tog_i = ~reg_tog_i;
    cyc(10);
    reg_icg_on_i = 1'b0;
    cyc(10);
    reg_icg_on_i = 1'b1;
    cyc(10);

    // Reset while a request is pending.
    reg_div_i = 4'd4;
    reg_tog_i = ~reg_tog_i;
    cyc(14);
    check("div4_cur", {28'd0, div_cur_o}, 32'd4);
    reg_div_i = 4'd9;
    reg_tog_i = ~reg_tog_i;
    cyc(3);
    check("busy_before_rst", {31'd0, busy_o}, 32'd1);
    #2;
    p_rst = 1'b1;
    #1;
    model_reset();
    check("rst_clk_en", {31'd0, clk_en_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_upd", {31'd0, upd_done_o}, 32'd0);
    check("rst_div", {28'd0, div_cur_o}, 32'd0);
    reg_tog_i = 1'b1;
    cyc(2);
    p_rst = 1'b0;
    cyc(12);
    check("post_rst_div", {28'd0, div_cur_o}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) reg_div_i = 4'($urandom_range(15));
      if ($urandom_range(9) == 0) reg_tog_i = ~reg_tog_i;
      if ($urandom_range(39) == 0) reg_cken_i = ~reg_cken_i;
      if ($urandom_range(14) == 0) reg_icg_on_i = ~reg_icg_on_i;
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
